// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
//   Bundles the three handshakes of the load/store stage:
//     in_*   : instruction from the execute stage (valid/ready)
//     mem_*  : data-RAM request/grant/response bus
//     out_*  : register writeback result (valid/ready)
//   Modports:
//     slave  : the mem_stage view (consumes in_*, drives mem_* requests,
//              drives out_*)
//     master : the surrounding pipeline / memory view (the opposite side)
// ---------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  // execute -> mem handshake
  logic              in_valid;
  logic              in_ready;
  logic              in_ld;
  logic              in_st;
  logic [2:0]        in_funct3;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              in_rd_en;
  logic [4:0]        in_rd_addr;

  // data-RAM bus
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // writeback handshake
  logic              out_valid;
  logic              out_ready;
  logic              out_rd_en;
  logic [4:0]        out_rd_addr;
  logic [DATA_W-1:0] out_rd_data;
  logic              out_misalign;

  modport slave (
    input  in_valid, in_ld, in_st, in_funct3, in_addr, in_wdata,
           in_rd_en, in_rd_addr,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output out_valid, out_rd_en, out_rd_addr, out_rd_data, out_misalign,
    input  out_ready
  );

  modport master (
    output in_valid, in_ld, in_st, in_funct3, in_addr, in_wdata,
           in_rd_en, in_rd_addr,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  out_valid, out_rd_en, out_rd_addr, out_rd_data, out_misalign,
    output out_ready
  );

endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Load/store pipeline stage. Takes one executed instruction at a time,
//   performs its data-RAM access over a request/grant/response bus, and
//   presents a register-writeback result. Non-memory ops pass through with
//   one register stage of latency. Handles byte-lane steering, the 64-bit
//   per-bit write mask and load sign/zero extension.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : mem_stage_if.slave (in_* from execute, mem_* to data RAM,
//          out_* to writeback)
//
// Configuration macro:
//   MEM_MISALIGN_TRAP_EN  defined   -> misaligned loads/stores issue no bus
//                                      request and complete immediately as
//                                      a fault (out_misalign=1, result is
//                                      the faulting address)
//                         undefined -> the byte offset is forced to natural
//                                      alignment and the access proceeds;
//                                      out_misalign is constant 0
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              ready_q;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wmask_q, mem_wmask_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [2:0]        off_q, off_d;
  logic              rd_en_q, rd_en_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_q, misalign_d;
  logic              misaligned;
`endif

  logic [2:0]        in_off;
  logic [2:0]        aligned_off;
  logic [5:0]        shamt;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] shifted_rdata;
  logic [DATA_W-1:0] load_data;
  logic              is_mem;
  logic              accept;

  // Accept only once out of reset and when no result is still waiting.
  assign bus.in_ready     = ready_q && (state_q == IDLE) &&
                            (!bus.out_valid || bus.out_ready);
  assign accept           = bus.in_valid && bus.in_ready;
  assign is_mem           = bus.in_ld || bus.in_st;

  assign bus.mem_req      = (state_q == REQ);
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wmask    = mem_wmask_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_rd_en    = rd_en_q;
  assign bus.out_rd_addr  = rd_addr_q;
  assign bus.out_rd_data  = rd_data_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign bus.out_misalign = misalign_q;
`else
  assign bus.out_misalign = 1'b0;
`endif

  // Lane selection for the incoming access. funct3[1:0] is the access size
  // for both loads and stores (funct3=111 therefore behaves as a doubleword).
  // The offset is snapped to natural alignment so a misaligned access that
  // is allowed to proceed stays inside the addressed doubleword.
  always_comb begin
    in_off      = bus.in_addr[2:0];
    aligned_off = in_off;
    lane_mask   = '1;
    case (bus.in_funct3[1:0])
      2'b00: begin
        aligned_off = in_off;
        lane_mask   = 64'h0000_0000_0000_00FF;
      end
      2'b01: begin
        aligned_off = {in_off[2:1], 1'b0};
        lane_mask   = 64'h0000_0000_0000_FFFF;
      end
      2'b10: begin
        aligned_off = {in_off[2], 2'b00};
        lane_mask   = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        aligned_off = 3'b000;
        lane_mask   = '1;
      end
    endcase
    shamt = {aligned_off, 3'b000};
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Any address bit below the natural alignment of the size is a fault.
  always_comb begin
    misaligned = 1'b0;
    case (bus.in_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_off[0];
      2'b10:   misaligned = |in_off[1:0];
      default: misaligned = |in_off;
    endcase
  end
`endif

  // Load result: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_rdata = bus.mem_rdata >> {off_q, 3'b000};
    load_data     = shifted_rdata;
    case (funct3_q)
      3'b000:  load_data = {{56{shifted_rdata[7]}},  shifted_rdata[7:0]};
      3'b001:  load_data = {{48{shifted_rdata[15]}}, shifted_rdata[15:0]};
      3'b010:  load_data = {{32{shifted_rdata[31]}}, shifted_rdata[31:0]};
      3'b100:  load_data = {56'd0, shifted_rdata[7:0]};
      3'b101:  load_data = {48'd0, shifted_rdata[15:0]};
      3'b110:  load_data = {32'd0, shifted_rdata[31:0]};
      default: load_data = shifted_rdata;
    endcase
  end

  // Next-state and datapath updates. Bus fields are captured at accept and
  // then held untouched through REQ so they stay stable until the grant.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_addr_d = bus.in_rd_addr;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_d = 1'b0;
`endif
          if (!is_mem) begin
            rd_en_d   = bus.in_rd_en;
            rd_data_d = bus.in_addr;
            state_d   = DONE;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          else if (misaligned) begin
            rd_en_d    = 1'b0;
            rd_data_d  = bus.in_addr;
            misalign_d = 1'b1;
            state_d    = DONE;
          end
`endif
          else begin
            // both ld and st set is handled as a store
            mem_we_d    = bus.in_st;
            mem_addr_d  = {bus.in_addr[ADDR_W-1:3], 3'b000};
            mem_wmask_d = bus.in_st ? (lane_mask << shamt) : '0;
            mem_wdata_d = bus.in_st ? (bus.in_wdata << shamt) : '0;
            funct3_d    = bus.in_funct3;
            off_d       = aligned_off;
            rd_en_d     = bus.in_rd_en;
            rd_data_d   = '0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          if (mem_we_q) begin
            rd_en_d = 1'b0;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          rd_data_d = load_data;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. ready_q holds off in_ready for the first
  // cycle after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      funct3_q    <= 3'b000;
      off_q       <= 3'b000;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 5'd0;
      rd_data_q   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Directed bench for mem_stage: reset behaviour, non-memory passthrough,
//   store lane steering with delayed grant, loads with sign/zero extension,
//   a response in the grant cycle that must be ignored, writeback
//   back-pressure, misaligned access (both builds of MEM_MISALIGN_TRAP_EN)
//   and reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_stage_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_stage #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the execute-side inputs.
  task automatic applyStimulus(input logic valid, input logic ld,
                               input logic st, input logic [2:0] funct3,
                               input logic [63:0] addr,
                               input logic [63:0] wdata,
                               input logic rd_en, input logic [4:0] rd_addr);
    bus.in_valid   = valid;
    bus.in_ld      = ld;
    bus.in_st      = st;
    bus.in_funct3  = funct3;
    bus.in_addr    = addr;
    bus.in_wdata   = wdata;
    bus.in_rd_en   = rd_en;
    bus.in_rd_addr = rd_addr;
  endtask

  // One comparison against a hand-computed value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Load with grant on the first REQ cycle and data one cycle later.
  task automatic runLoad(input string tag, input logic [2:0] funct3,
                         input logic [63:0] addr, input logic [63:0] rdata,
                         input logic [4:0] rd_addr,
                         input logic [63:0] exp_addr,
                         input logic [63:0] exp_data);
    applyStimulus(1'b1, 1'b1, 1'b0, funct3, addr, 64'd0, 1'b1, rd_addr);
    tick();
    bus.in_valid = 1'b0;
    checkOutput({tag, "_req"}, {63'd0, bus.mem_req}, 64'd1);
    checkOutput({tag, "_addr"}, bus.mem_addr, exp_addr);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    tick();
    bus.mem_rvalid = 1'b0;
    checkOutput({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    checkOutput({tag, "_data"}, bus.out_rd_data, exp_data);
    checkOutput({tag, "_misalign"}, {63'd0, bus.out_misalign}, 64'd0);
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst            = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 64'd0;
    bus.out_ready  = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 1'b1, 5'd5);

    // reset held with a valid input present
    tick();
    tick();
    checkOutput("rst_req", {63'd0, bus.mem_req}, 64'd0);
    checkOutput("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    checkOutput("rst_addr", bus.mem_addr, 64'd0);
    checkOutput("rst_wmask", bus.mem_wmask, 64'd0);
    checkOutput("rst_rd_data", bus.out_rd_data, 64'd0);
    checkOutput("rst_misalign", {63'd0, bus.out_misalign}, 64'd0);

    bus.in_valid = 1'b0;
    rst = 1'b1;
    checkOutput("release_ready0", {63'd0, bus.in_ready}, 64'd0);
    tick();
    checkOutput("release_ready1", {63'd0, bus.in_ready}, 64'd1);

    // non-memory passthrough
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 1'b1, 5'd5);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("alu_valid", {63'd0, bus.out_valid}, 64'd1);
    checkOutput("alu_data", bus.out_rd_data, 64'h1234);
    checkOutput("alu_rd_addr", {59'd0, bus.out_rd_addr}, 64'd5);
    checkOutput("alu_rd_en", {63'd0, bus.out_rd_en}, 64'd1);
    checkOutput("alu_in_ready", {63'd0, bus.in_ready}, 64'd0);
    tick();
    checkOutput("alu_idle", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("alu_ready", {63'd0, bus.in_ready}, 64'd1);

    // sb at 0x1003, grant after 3 request cycles
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b000, 64'h1003, 64'hAB, 1'b1, 5'd3);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("sb_req1", {63'd0, bus.mem_req}, 64'd1);
    checkOutput("sb_we", {63'd0, bus.mem_we}, 64'd1);
    checkOutput("sb_addr", bus.mem_addr, 64'h1000);
    checkOutput("sb_wmask", bus.mem_wmask, 64'h0000_0000_FF00_0000);
    checkOutput("sb_wdata", bus.mem_wdata, 64'h0000_0000_AB00_0000);
    tick();
    checkOutput("sb_req2", {63'd0, bus.mem_req}, 64'd1);
    checkOutput("sb_wait_valid", {63'd0, bus.out_valid}, 64'd0);
    tick();
    checkOutput("sb_req3", {63'd0, bus.mem_req}, 64'd1);
    checkOutput("sb_addr_hold", bus.mem_addr, 64'h1000);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    checkOutput("sb_valid", {63'd0, bus.out_valid}, 64'd1);
    checkOutput("sb_rd_en", {63'd0, bus.out_rd_en}, 64'd0);
    checkOutput("sb_req_drop", {63'd0, bus.mem_req}, 64'd0);
    tick();

    // sw at 0x1004, immediate grant
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 64'h1004, 64'h1122_3344, 1'b0, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("sw_wmask", bus.mem_wmask, 64'hFFFF_FFFF_0000_0000);
    checkOutput("sw_wdata", bus.mem_wdata, 64'h1122_3344_0000_0000);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    checkOutput("sw_valid", {63'd0, bus.out_valid}, 64'd1);
    tick();

    // lb at 0x2006; response in the grant cycle must be ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 64'h2006, 64'd0, 1'b1, 5'd7);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("lb_we", {63'd0, bus.mem_we}, 64'd0);
    checkOutput("lb_addr", bus.mem_addr, 64'h2000);
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h0055_0000_0000_0000;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    checkOutput("lb_gnt_rvalid_ignored", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("lb_req_drop", {63'd0, bus.mem_req}, 64'd0);
    tick();
    checkOutput("lb_wait", {63'd0, bus.out_valid}, 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h0080_0000_0000_0000;
    tick();
    bus.mem_rvalid = 1'b0;
    checkOutput("lb_valid", {63'd0, bus.out_valid}, 64'd1);
    checkOutput("lb_data", bus.out_rd_data, 64'hFFFF_FFFF_FFFF_FF80);
    checkOutput("lb_rd_addr", {59'd0, bus.out_rd_addr}, 64'd7);
    checkOutput("lb_rd_en", {63'd0, bus.out_rd_en}, 64'd1);
    tick();

    // lbu at 0x2006 with writeback back-pressure for 4 cycles
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b100, 64'h2006, 64'd0, 1'b1, 5'd8);
    tick();
    bus.in_valid = 1'b0;
    bus.mem_gnt  = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h0080_0000_0000_0000;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_valid", {63'd0, bus.out_valid}, 64'd1);
      checkOutput("bp_lbu_data", bus.out_rd_data, 64'h80);
      checkOutput("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp_release", {63'd0, bus.out_valid}, 64'd0);

    // more load extensions
    runLoad("lh", 3'b001, 64'h4002, 64'h0000_0000_ABCD_0000, 5'd9,
            64'h4000, 64'hFFFF_FFFF_FFFF_ABCD);
    runLoad("lhu", 3'b101, 64'h4002, 64'h0000_0000_ABCD_0000, 5'd9,
            64'h4000, 64'h0000_0000_0000_ABCD);
    runLoad("lwu", 3'b110, 64'h4004, 64'h8765_4321_0000_0000, 5'd10,
            64'h4000, 64'h0000_0000_8765_4321);
    runLoad("ld", 3'b011, 64'h5000, 64'h0123_4567_89AB_CDEF, 5'd11,
            64'h5000, 64'h0123_4567_89AB_CDEF);
    runLoad("f3_111", 3'b111, 64'h5000, 64'hFEDC_BA98_7654_3210, 5'd12,
            64'h5000, 64'hFEDC_BA98_7654_3210);

    // misaligned lw at 0x3002
`ifdef MEM_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 64'h3002, 64'd0, 1'b1, 5'd13);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("mis_no_req", {63'd0, bus.mem_req}, 64'd0);
    checkOutput("mis_valid", {63'd0, bus.out_valid}, 64'd1);
    checkOutput("mis_flag", {63'd0, bus.out_misalign}, 64'd1);
    checkOutput("mis_data", bus.out_rd_data, 64'h3002);
    checkOutput("mis_rd_en", {63'd0, bus.out_rd_en}, 64'd0);
    tick();
`else
    runLoad("mis_lw", 3'b010, 64'h3002, 64'h1111_2222_8765_4321, 5'd13,
            64'h3000, 64'hFFFF_FFFF_8765_4321);
`endif

    // reset in the middle of a load, then a late response
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 64'h6000, 64'd0, 1'b1, 5'd14);
    tick();
    bus.in_valid = 1'b0;
    bus.mem_gnt  = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("midrst_req", {63'd0, bus.mem_req}, 64'd0);
    checkOutput("midrst_addr", bus.mem_addr, 64'd0);
    checkOutput("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
    tick();
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h0123_4567_89AB_CDEF;
    tick();
    bus.mem_rvalid = 1'b0;
    checkOutput("late_rvalid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("late_rd_data", bus.out_rd_data, 64'd0);
    checkOutput("post_rst_ready", {63'd0, bus.in_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
